// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: hazard-controller states, per-register control
// bundle, NOP encoding and the load-use detection helper.
package mips_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } hz_state_t;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic pc_we;
        logic if_id_freeze;
        logic if_id_flush;
        logic id_exe_freeze;
        logic id_exe_bubble;
        logic exe_mem_freeze;
        logic mem_wb_freeze;
    } hz_ctrl_t;

    // A load writing $zero never creates a real dependency.
    function automatic logic load_use_hazard(
        input logic       exe_mem_read,
        input logic [4:0] exe_rd,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       uses_rt
    );
        return exe_mem_read && (exe_rd != REG_ZERO) &&
               ((exe_rd == id_rs) || (uses_rt && (exe_rd == id_rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q_reg <= '0;
        end else if (clr) begin
            q_reg <= '0;
        end else if (inc && !(&q_reg)) begin
            q_reg <= q_reg + 1'b1;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage pipeline: cache-miss freeze,
// load-use bubble, taken-branch flush and halt drain, plus perf counters.
module pipeline_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16,
    parameter int MISS_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [4:0]       id_rs_num,
    input  logic [4:0]       id_rt_num,
    input  logic             id_uses_rt,
    input  logic             exe_mem_read,
    input  logic [4:0]       exe_rd_num,
    input  logic             id_branch_taken,
    input  logic             mem_access,
    input  logic             mem_hit,
    input  logic             id_halt,
    output logic             pc_we,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_exe_freeze,
    output logic             id_exe_bubble,
    output logic             exe_mem_freeze,
    output logic             mem_wb_freeze,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             miss_timeout
);

    localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam int TMR_W   = $clog2(MISS_TIMEOUT + 1);

    hz_state_t          state_reg, state_next;
    logic [DRAIN_W-1:0] drain_reg, drain_next;
    logic               halted_reg;
    logic               timeout_reg;
    logic               miss;
    logic               lu;
    logic               stall_inc;
    logic               flush_inc;
    hz_ctrl_t           ctrl;
    logic [TMR_W-1:0]   miss_run;
    logic [1:0]         perf_inc;
    logic [CNT_W-1:0]   perf_q [2];

    assign miss = mem_access & ~mem_hit;
    assign lu   = load_use_hazard(exe_mem_read, exe_rd_num, id_rs_num, id_rt_num, id_uses_rt);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg   <= RUN;
            drain_reg   <= DRAIN_W'(DRAIN_CYCLES);
            halted_reg  <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            drain_reg   <= drain_next;
            halted_reg  <= (state_next == HALT);
            timeout_reg <= timeout_reg | (miss & (miss_run >= TMR_W'(MISS_TIMEOUT - 1)));
        end
    end

    always_comb begin
        state_next = state_reg;
        drain_next = drain_reg;
        case (state_reg)
            RUN: begin
                drain_next = DRAIN_W'(DRAIN_CYCLES);
                if (!miss && !lu && id_halt) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // A miss stalls the older instructions, so the drain count holds.
                if (!miss) begin
                    drain_next = drain_reg - 1'b1;
                    if (drain_reg <= DRAIN_W'(1)) begin
                        state_next = HALT;
                    end
                end
            end
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        ctrl      = '0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_reg)
            RUN: begin
                if (miss) begin
                    ctrl.if_id_freeze   = 1'b1;
                    ctrl.id_exe_freeze  = 1'b1;
                    ctrl.exe_mem_freeze = 1'b1;
                    ctrl.mem_wb_freeze  = 1'b1;
                    stall_inc           = 1'b1;
                end else if (lu) begin
                    // Branch outcome used stale operands, so it is not acted on.
                    ctrl.if_id_freeze  = 1'b1;
                    ctrl.id_exe_bubble = 1'b1;
                    stall_inc          = 1'b1;
                end else if (id_halt) begin
                    ctrl.if_id_flush   = 1'b1;
                    ctrl.id_exe_bubble = 1'b1;
                end else if (id_branch_taken) begin
                    ctrl.pc_we       = 1'b1;
                    ctrl.if_id_flush = 1'b1;
                    flush_inc        = 1'b1;
                end else begin
                    ctrl.pc_we = 1'b1;
                end
            end
            DRAIN: begin
                if (miss) begin
                    ctrl.if_id_freeze   = 1'b1;
                    ctrl.id_exe_freeze  = 1'b1;
                    ctrl.exe_mem_freeze = 1'b1;
                    ctrl.mem_wb_freeze  = 1'b1;
                    stall_inc           = 1'b1;
                end else begin
                    ctrl.if_id_flush   = 1'b1;
                    ctrl.id_exe_bubble = 1'b1;
                end
            end
            HALT: begin
                ctrl.if_id_freeze   = 1'b1;
                ctrl.id_exe_freeze  = 1'b1;
                ctrl.exe_mem_freeze = 1'b1;
                ctrl.mem_wb_freeze  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign perf_inc = {flush_inc, stall_inc};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            sat_counter #(.W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_b (rst_b),
                .clr   (1'b0),
                .inc   (perf_inc[gi]),
                .q     (perf_q[gi])
            );
        end
    endgenerate

    sat_counter #(.W(TMR_W)) u_miss_timer (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (~miss),
        .inc   (miss),
        .q     (miss_run)
    );

    assign pc_we          = ctrl.pc_we;
    assign if_id_freeze   = ctrl.if_id_freeze;
    assign if_id_flush    = ctrl.if_id_flush;
    assign id_exe_freeze  = ctrl.id_exe_freeze;
    assign id_exe_bubble  = ctrl.id_exe_bubble;
    assign exe_mem_freeze = ctrl.exe_mem_freeze;
    assign mem_wb_freeze  = ctrl.mem_wb_freeze;
    assign halted         = halted_reg;
    assign stall_cnt      = perf_q[0];
    assign flush_cnt      = perf_q[1];
    assign miss_timeout   = timeout_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; narrow counters so saturation is
// reachable within the miss-timeout scenario.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 6;

    // Control vector order: pc_we, if_id_freeze, if_id_flush, id_exe_freeze,
    // id_exe_bubble, exe_mem_freeze, mem_wb_freeze
    localparam logic [6:0] C_IDLE   = 7'b1000000;
    localparam logic [6:0] C_LU     = 7'b0100100;
    localparam logic [6:0] C_FREEZE = 7'b0101011;
    localparam logic [6:0] C_BRANCH = 7'b1010000;
    localparam logic [6:0] C_KILL   = 7'b0010100;

    logic clk = 1'b0;
    logic rst_b;
    logic [4:0] id_rs_num, id_rt_num, exe_rd_num;
    logic id_uses_rt, exe_mem_read, id_branch_taken, mem_access, mem_hit, id_halt;
    logic pc_we, if_id_freeze, if_id_flush, id_exe_freeze, id_exe_bubble;
    logic exe_mem_freeze, mem_wb_freeze, halted, miss_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0] ctrl;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .DRAIN_CYCLES (3),
        .CNT_W        (CNT_W),
        .MISS_TIMEOUT (64)
    ) dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .id_rs_num       (id_rs_num),
        .id_rt_num       (id_rt_num),
        .id_uses_rt      (id_uses_rt),
        .exe_mem_read    (exe_mem_read),
        .exe_rd_num      (exe_rd_num),
        .id_branch_taken (id_branch_taken),
        .mem_access      (mem_access),
        .mem_hit         (mem_hit),
        .id_halt         (id_halt),
        .pc_we           (pc_we),
        .if_id_freeze    (if_id_freeze),
        .if_id_flush     (if_id_flush),
        .id_exe_freeze   (id_exe_freeze),
        .id_exe_bubble   (id_exe_bubble),
        .exe_mem_freeze  (exe_mem_freeze),
        .mem_wb_freeze   (mem_wb_freeze),
        .halted          (halted),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .miss_timeout    (miss_timeout)
    );

    assign ctrl = {pc_we, if_id_freeze, if_id_flush, id_exe_freeze,
                   id_exe_bubble, exe_mem_freeze, mem_wb_freeze};

    task automatic clear_inputs();
        id_rs_num = 5'd0; id_rt_num = 5'd0; exe_rd_num = 5'd0;
        id_uses_rt = 1'b0; exe_mem_read = 1'b0; id_branch_taken = 1'b0;
        mem_access = 1'b0; mem_hit = 1'b0; id_halt = 1'b0;
    endtask

    // One clock cycle, ending on the falling edge; logs the transaction.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        $display("[%0t] ctrl=%b halted=%b stall=%0d flush=%0d timeout=%b",
                 $time, ctrl, halted, stall_cnt, flush_cnt, miss_timeout);
    endtask

    task automatic apply_reset();
        rst_b = 1'b0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        #1 rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_b = 1'b1;
        #1 rst_b = 1'b0;
        #1;
        n_checks++; if (ctrl !== C_IDLE) begin n_fail++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_IDLE); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
        n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
        n_checks++; if (flush_cnt !== '0) begin n_fail++; $display("FAIL reset_flush: got %0d expected 0", flush_cnt); end
        n_checks++; if (miss_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", miss_timeout); end
        @(negedge clk);
        rst_b = 1'b1;
        $display("[%0t] reset released", $time);
    endtask

    task automatic test_load_use();
        exe_mem_read = 1'b1; exe_rd_num = 5'd8; id_rs_num = 5'd8;
        #1;
        n_checks++; if (ctrl !== C_LU) begin n_fail++; $display("FAIL lu_rs_ctrl: got %b expected %b", ctrl, C_LU); end
        exp_stall++;
        tick();
        n_checks++; if (stall_cnt !== CNT_W'(exp_stall)) begin n_fail++; $display("FAIL lu_rs_stall: got %0d expected %0d", stall_cnt, exp_stall); end
        exe_rd_num = 5'd0; id_rs_num = 5'd0;
        #1;
        n_checks++; if (ctrl !== C_IDLE) begin n_fail++; $display("FAIL lu_zero_ctrl: got %b expected %b", ctrl, C_IDLE); end
        tick();
        n_checks++; if (stall_cnt !== CNT_W'(exp_stall)) begin n_fail++; $display("FAIL lu_zero_stall: got %0d expected %0d", stall_cnt, exp_stall); end
        exe_rd_num = 5'd9; id_rs_num = 5'd3; id_rt_num = 5'd9; id_uses_rt = 1'b1;
        #1;
        n_checks++; if (ctrl !== C_LU) begin n_fail++; $display("FAIL lu_rt_ctrl: got %b expected %b", ctrl, C_LU); end
        exp_stall++;
        tick();
        id_uses_rt = 1'b0;
        #1;
        n_checks++; if (ctrl !== C_IDLE) begin n_fail++; $display("FAIL lu_rt_unused_ctrl: got %b expected %b", ctrl, C_IDLE); end
        tick();
        n_checks++; if (stall_cnt !== CNT_W'(exp_stall)) begin n_fail++; $display("FAIL lu_rt_stall: got %0d expected %0d", stall_cnt, exp_stall); end
        clear_inputs();
    endtask

    task automatic test_miss_priority();
        mem_access = 1'b1; mem_hit = 1'b0;
        exe_mem_read = 1'b1; exe_rd_num = 5'd8; id_rs_num = 5'd8; id_branch_taken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (ctrl !== C_FREEZE) begin n_fail++; $display("FAIL miss_ctrl[%0d]: got %b expected %b", i, ctrl, C_FREEZE); end
            exp_stall++;
            tick();
        end
        n_checks++; if (stall_cnt !== CNT_W'(exp_stall)) begin n_fail++; $display("FAIL miss_stall: got %0d expected %0d", stall_cnt, exp_stall); end
        n_checks++; if (flush_cnt !== CNT_W'(exp_flush)) begin n_fail++; $display("FAIL miss_flush: got %0d expected %0d", flush_cnt, exp_flush); end
        clear_inputs();
    endtask

    task automatic test_branch();
        id_branch_taken = 1'b1;
        #1;
        n_checks++; if (ctrl !== C_BRANCH) begin n_fail++; $display("FAIL br_ctrl: got %b expected %b", ctrl, C_BRANCH); end
        exp_flush++;
        tick();
        n_checks++; if (flush_cnt !== CNT_W'(exp_flush)) begin n_fail++; $display("FAIL br_flush: got %0d expected %0d", flush_cnt, exp_flush); end
        exe_mem_read = 1'b1; exe_rd_num = 5'd4; id_rs_num = 5'd4;
        #1;
        n_checks++; if (ctrl !== C_LU) begin n_fail++; $display("FAIL br_lu_ctrl: got %b expected %b", ctrl, C_LU); end
        exp_stall++;
        tick();
        n_checks++; if (flush_cnt !== CNT_W'(exp_flush)) begin n_fail++; $display("FAIL br_lu_flush: got %0d expected %0d", flush_cnt, exp_flush); end
        n_checks++; if (stall_cnt !== CNT_W'(exp_stall)) begin n_fail++; $display("FAIL br_lu_stall: got %0d expected %0d", stall_cnt, exp_stall); end
        clear_inputs();
    endtask

    task automatic test_halt_drain();
        id_halt = 1'b1;
        #1;
        n_checks++; if (ctrl !== C_KILL) begin n_fail++; $display("FAIL halt_dec_ctrl: got %b expected %b", ctrl, C_KILL); end
        tick();
        // Branch and a second halt in DRAIN must have no effect.
        id_branch_taken = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            #1;
            n_checks++; if (ctrl !== C_KILL) begin n_fail++; $display("FAIL drain_ctrl[%0d]: got %b expected %b", i, ctrl, C_KILL); end
            n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL drain_halted[%0d]: got %b expected 0", i, halted); end
            tick();
            clear_inputs();
        end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_edge4: got %b expected 1", halted); end
        n_checks++; if (ctrl !== C_FREEZE) begin n_fail++; $display("FAIL halt_ctrl: got %b expected %b", ctrl, C_FREEZE); end
        n_checks++; if (flush_cnt !== CNT_W'(exp_flush)) begin n_fail++; $display("FAIL drain_flush: got %0d expected %0d", flush_cnt, exp_flush); end
        mem_access = 1'b1; id_branch_taken = 1'b1;
        tick();
        tick();
        n_checks++; if (stall_cnt !== CNT_W'(exp_stall)) begin n_fail++; $display("FAIL halt_nostall: got %0d expected %0d", stall_cnt, exp_stall); end
        n_checks++; if (flush_cnt !== CNT_W'(exp_flush)) begin n_fail++; $display("FAIL halt_noflush: got %0d expected %0d", flush_cnt, exp_flush); end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %b expected 1", halted); end
        clear_inputs();

        apply_reset();
        id_halt = 1'b1;
        tick();
        clear_inputs();
        mem_access = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (ctrl !== C_FREEZE) begin n_fail++; $display("FAIL drain_miss_ctrl[%0d]: got %b expected %b", i, ctrl, C_FREEZE); end
            exp_stall++;
            tick();
        end
        clear_inputs();
        tick();
        tick();
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL drain_miss_early: got %b expected 0", halted); end
        tick();
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL drain_miss_halted: got %b expected 1", halted); end
        n_checks++; if (stall_cnt !== CNT_W'(exp_stall)) begin n_fail++; $display("FAIL drain_miss_stall: got %0d expected %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        id_halt = 1'b1;
        tick();
        clear_inputs();
        mem_access = 1'b1;
        tick();
        #3 rst_b = 1'b0;
        #1;
        n_checks++; if (ctrl !== C_FREEZE) begin n_fail++; $display("FAIL arst_miss_ctrl: got %b expected %b", ctrl, C_FREEZE); end
        n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL arst_stall: got %0d expected 0", stall_cnt); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL arst_halted: got %b expected 0", halted); end
        clear_inputs();
        #1;
        n_checks++; if (ctrl !== C_IDLE) begin n_fail++; $display("FAIL arst_run_ctrl: got %b expected %b", ctrl, C_IDLE); end
        exp_stall = 0;
        exp_flush = 0;
        @(negedge clk);
        rst_b = 1'b1;
        id_branch_taken = 1'b1;
        #1;
        n_checks++; if (ctrl !== C_BRANCH) begin n_fail++; $display("FAIL arst_br_ctrl: got %b expected %b", ctrl, C_BRANCH); end
        exp_flush++;
        tick();
        n_checks++; if (flush_cnt !== CNT_W'(exp_flush)) begin n_fail++; $display("FAIL arst_br_flush: got %0d expected %0d", flush_cnt, exp_flush); end
        clear_inputs();
        id_halt = 1'b1;
        tick();
        clear_inputs();
        tick();
        tick();
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL arst_drain_early: got %b expected 0", halted); end
        tick();
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL arst_drain_halted: got %b expected 1", halted); end
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_access = 1'b1; mem_hit = 1'b0;
        repeat (63) tick();
        n_checks++; if (miss_timeout !== 1'b0) begin n_fail++; $display("FAIL to_63: got %b expected 0", miss_timeout); end
        mem_hit = 1'b1;
        #1;
        n_checks++; if (ctrl !== C_IDLE) begin n_fail++; $display("FAIL to_hit_ctrl: got %b expected %b", ctrl, C_IDLE); end
        tick();
        mem_hit = 1'b0;
        repeat (63) tick();
        n_checks++; if (miss_timeout !== 1'b0) begin n_fail++; $display("FAIL to_restart_63: got %b expected 0", miss_timeout); end
        tick();
        n_checks++; if (miss_timeout !== 1'b1) begin n_fail++; $display("FAIL to_64: got %b expected 1", miss_timeout); end
        mem_hit = 1'b1;
        #1;
        n_checks++; if (ctrl !== C_IDLE) begin n_fail++; $display("FAIL to_flag_ctrl: got %b expected %b", ctrl, C_IDLE); end
        repeat (3) tick();
        n_checks++; if (miss_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", miss_timeout); end
        // 127 miss cycles in total: a 6-bit counter must sit at all-ones.
        n_checks++; if (stall_cnt !== 6'h3F) begin n_fail++; $display("FAIL stall_saturate: got %0d expected 63", stall_cnt); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_miss_priority();
        test_branch();
        test_halt_drain();
        test_async_reset();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/halt sequencer for the 5-stage MIPS pipeline (IF, ID, EXE, MEM, WB).
- Combines three conditions into per-register control:
  - cache-miss freeze from MEM;
  - load-use hazard between ID and EXE;
  - taken branch/jump resolved in ID.
- Sequences program halt: kills younger instructions, drains older ones to WB, then raises halted.
- Drives PC write enable and the freeze/flush/bubble inputs of IF_to_ID, ID_to_EXE, EXE_to_MEM and MEM_to_WB.

Parameters:
- DRAIN_CYCLES, 3, advancing cycles needed after halt decode for EXE/MEM/WB occupants to retire.
- CNT_W, 16, width of the saturating performance counters.
- MISS_TIMEOUT, 64, consecutive miss-freeze cycles before miss_timeout is flagged.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- id_rs_num  in  5  rs field of instruction in ID.
- id_rt_num  in  5  rt field of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt (R-type, branch-eq/ne, store).
- exe_mem_read  in  1  instruction in EXE is a load.
- exe_rd_num  in  5  destination register of EXE instruction.
- id_branch_taken  in  1  branch/jump/jr in ID resolves taken.
- mem_access  in  1  MEM stage holds a valid cache access.
- mem_hit  in  1  cache hit; 0 with mem_access=1 means refill in progress.
- id_halt  in  1  halt instruction decoded in ID.
- pc_we  out  1  PC register update enable.
- if_id_freeze  out  1  hold IF_to_ID.
- if_id_flush  out  1  load NOP into IF_to_ID.
- id_exe_freeze  out  1  hold ID_to_EXE.
- id_exe_bubble  out  1  load NOP (all control zero) into ID_to_EXE.
- exe_mem_freeze  out  1  hold EXE_to_MEM.
- mem_wb_freeze  out  1  hold MEM_to_WB.
- halted  out  1  registered; core has fully drained.
- stall_cnt  out  CNT_W  saturating count of freeze + load-use cycles.
- flush_cnt  out  CNT_W  saturating count of branch flushes.
- miss_timeout  out  1  sticky error flag.

Behaviour:
- Signal definitions:
  - miss = mem_access & ~mem_hit.
  - lu = exe_mem_read & (exe_rd_num != 0) & ((exe_rd_num == id_rs_num) | (id_uses_rt & exe_rd_num == id_rt_num)).
- Register timing: state, counters and halted are registered. All other outputs are combinational from state and inputs (zero-cycle latency).
- FSM states: RUN, DRAIN, HALT. Reset → RUN, drain counter = DRAIN_CYCLES, halted = 0, counters = 0, miss_timeout = 0.
- RUN, priority miss > lu > halt > branch:
  - miss: pc_we=0; all four freezes=1; flush and bubble=0; stall_cnt+1.
  - lu (no miss): pc_we=0; if_id_freeze=1; id_exe_bubble=1; exe_mem and mem_wb advance; stall_cnt+1. id_branch_taken is ignored because the branch was evaluated on stale data.
  - id_halt (no miss, no lu): pc_we=0; id_exe_bubble=1; if_id_flush=1; next state DRAIN.
  - id_branch_taken: pc_we=1; if_id_flush=1; flush_cnt+1.
  - otherwise: pc_we=1; all freeze/flush/bubble=0.
- DRAIN:
  - Every cycle: pc_we=0; if_id_flush=1; id_exe_bubble=1.
  - If miss: all freezes=1 and the counter holds.
  - Else: the counter decrements. Leaving the counter at 1 with no miss → HALT.
  - id_branch_taken and id_halt are ignored.
- HALT: halted=1 from the first HALT cycle; pc_we=0; all freezes=1; flush/bubble=0. Only reset exits.
- Reset mid-operation (any state, including DRAIN with a miss pending): immediate return to reset values; outputs follow RUN rules with reset state.
- Counters:
  - Saturate at all-ones, no wrap.
  - Do not count in HALT.
  - stall_cnt counts miss cycles in DRAIN.
- Miss timer: counts consecutive miss cycles and clears on any non-miss cycle. Reaching MISS_TIMEOUT sets miss_timeout, sticky until reset. The flag does not alter sequencing.
- Invariant: a stage marked freeze never receives a flush or bubble in the same cycle.

Decomposition:
- Shared package mips_pkg:
  - enum hz_state_t {RUN, DRAIN, HALT};
  - REG_ZERO constant (5'd0);
  - NOP encoding used by the flush/bubble consumers.
- One natural sub-module: sat_counter (parameter W; inputs inc, clr; saturating output), instantiated for stall_cnt, flush_cnt and the miss timer.

Test Plan:
- Load-use: exe_mem_read=1, exe_rd_num=8, id_rs_num=8 for 1 cycle → pc_we=0, if_id_freeze=1, id_exe_bubble=1, exe_mem_freeze=0, stall_cnt=1. Repeat with exe_rd_num=0 → no stall.
- Miss priority: mem_access=1, mem_hit=0 for 5 cycles with a coincident lu and id_branch_taken → all freezes=1 and no flush each cycle; stall_cnt=5; flush_cnt=0.
- Branch: id_branch_taken=1 alone → pc_we=1, if_id_flush=1, flush_cnt=1. Same cycle with lu → flush suppressed.
- Halt drain: id_halt=1 in RUN, then 3 clean cycles → halted rises on the 4th edge after decode. Inject a 2-cycle miss during DRAIN → halted rises 2 cycles later.
- Timeout: continuous miss for 64 cycles → miss_timeout=1 after the 64th; stays 1 after mem_hit=1.
- Async reset: assert rst_b=0 mid-DRAIN between clock edges → state RUN, halted=0, counters=0 immediately; sequencing resumes after release.
